spi_regfile_peripheral: RTL

Parametrised SPI-slave register file: the next-generation replacement for the fixed five-register SPI peripheral that configures the PWM peripheral in the Tiny Tapeout top. It oversamples SCLK/nCS/COPI in the system clock domain, decodes write and read frames of configurable address and data width, holds NUM_REGS registers, and drives read-back data on CIPO. Register contents feed the PWM peripheral and any future peripheral through a flattened bus.

---
 rtl/spi_regfile_pkg.sv | 13 +
 rtl/spi_sync.sv | 33 +++
 rtl/spi_regfile_peripheral.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, FULL} state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser followed by an edge-detect register for one SPI pin.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
      prev_reg <= RESET_VAL;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 slave register file: RW bit, address and data frames, oversampled in clk.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int SH_W      = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

  logic sclk_rise, sclk_fall, ncs_level, ncs_rise, ncs_fall, copi_level;
  logic unused_sclk_level, unused_copi_rise, unused_copi_fall, unused_sh_msb;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  // nCS idles high, so its synchroniser resets high to avoid a false fall.
  spi_sync #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_level), .rise(unused_copi_rise), .fall(unused_copi_fall)
  );

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovr_reg, ovr_next;
  logic [SH_W-1:0]     sh_reg, sh_next, sh_shift;
  logic                rw_reg, rw_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next, cmd_addr;
  logic [DATA_W-1:0]   rd_sh_reg, rd_sh_next, rd_word;
  logic                cipo_reg, cipo_next;
  logic                err_reg, err_next;
  logic                wr_en;

  assign sh_shift      = {sh_reg[SH_W-2:0], copi_level};
  assign cmd_addr      = sh_shift[ADDR_W-1:0];
  assign unused_sh_msb = sh_reg[SH_W-1];

  // Unimplemented addresses match no register and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) rd_word = regs[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ovr_reg   <= 1'b0;
      sh_reg    <= '0;
      rw_reg    <= 1'b0;
      addr_reg  <= '0;
      rd_sh_reg <= '0;
      cipo_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ovr_reg   <= ovr_next;
      sh_reg    <= sh_next;
      rw_reg    <= rw_next;
      addr_reg  <= addr_next;
      rd_sh_reg <= rd_sh_next;
      cipo_reg  <= cipo_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ovr_next   = ovr_reg;
    sh_next    = sh_reg;
    rw_next    = rw_reg;
    addr_next  = addr_reg;
    rd_sh_next = rd_sh_reg;
    cipo_next  = cipo_reg;
    err_next   = 1'b0;
    wr_en      = 1'b0;
    // A deselect outranks any SCLK edge seen in the same cycle.
    if (ncs_rise) begin
      state_next = IDLE;
      cipo_next  = 1'b0;
      if (state_reg != IDLE) begin
        if (state_reg == FULL && !ovr_reg) wr_en = (rw_reg == RW_WRITE);
        else                               err_next = 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: if (ncs_fall) begin
          state_next = CMD;
          cnt_next   = '0;
          ovr_next   = 1'b0;
          cipo_next  = 1'b0;
        end
        CMD: if (sclk_rise) begin
          sh_next  = sh_shift;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(ADDR_W)) begin
            state_next = DATA;
            rw_next    = sh_shift[ADDR_W];
            addr_next  = cmd_addr;
            rd_sh_next = rd_word;
          end
        end else if (sclk_fall) begin
          cipo_next = 1'b0;
        end
        DATA: if (sclk_rise) begin
          sh_next  = sh_shift;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(FRAME_LEN - 1)) state_next = FULL;
        end else if (sclk_fall) begin
          cipo_next  = (rw_reg == RW_READ) & rd_sh_reg[DATA_W-1];
          rd_sh_next = rd_sh_reg << 1;
        end
        FULL: if (sclk_rise) begin
          ovr_next = 1'b1;
        end else if (sclk_fall) begin
          cipo_next = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] value_reg;
    logic              strobe_reg;
    logic              hit;

    assign hit = wr_en && (addr_reg == ADDR_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_reg  <= '0;
        strobe_reg <= 1'b0;
      end else begin
        strobe_reg <= hit;
        if (hit) value_reg <= sh_reg[DATA_W-1:0];
      end
    end

    assign regs[gi*DATA_W +: DATA_W] = value_reg;
    assign wr_strobe[gi]             = strobe_reg;
  end

  assign cipo      = cipo_reg;
  assign cipo_oe   = ~ncs_level;
  assign frame_err = err_reg;

endmodule
